// File: rtl/comp_pkg.sv
// rtl/comp_pkg.sv - shared state and result encodings for the serial magnitude comparator
package comp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Result order is {A_greater_B, A_equal_B, A_less_B}
  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_GT   = 3'b100;
  localparam logic [2:0] RES_EQ   = 3'b010;
  localparam logic [2:0] RES_LT   = 3'b001;

endpackage

// File: rtl/bit_compare_cell.sv
// rtl/bit_compare_cell.sv - single-bit greater/less decision, sense inverted for a signed MSB
module bit_compare_cell (
  input  logic a_bit,
  input  logic b_bit,
  input  logic invert,
  output logic gt,
  output logic lt
);

  logic a_hi;
  logic b_hi;

  assign a_hi = a_bit & ~b_bit;
  assign b_hi = ~a_bit & b_bit;
  // A set sign bit marks the smaller two's-complement value
  assign gt   = invert ? b_hi : a_hi;
  assign lt   = invert ? a_hi : b_hi;

endmodule

// File: rtl/serial_magnitude_comparator.sv
// rtl/serial_magnitude_comparator.sv - MSB-first bit-serial compare with start/busy/done handshake
module serial_magnitude_comparator
  import comp_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             A_greater_B,
  output logic             A_equal_B,
  output logic             A_less_B
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] MSB_IDX = IW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             signed_q;
  logic [IW-1:0]    idx_q;
  logic [2:0]       dec_q;
  logic [2:0]       dec_d;
  logic [2:0]       flags_q;
  logic             busy_q;
  logic             done_q;
  logic             bit_gt;
  logic             bit_lt;
  logic             last_bit;

  bit_compare_cell u_cell (
    .a_bit  (a_q[idx_q]),
    .b_bit  (b_q[idx_q]),
    .invert (signed_q && (idx_q == MSB_IDX)),
    .gt     (bit_gt),
    .lt     (bit_lt)
  );

  // dec_q keeps the first decision through a full scan; flags stay 000 until DONE
  always_comb begin
    dec_d = dec_q;
    if (dec_q == RES_NONE) begin
      if (bit_gt)      dec_d = RES_GT;
      else if (bit_lt) dec_d = RES_LT;
    end
  end

  assign last_bit = (idx_q == '0) || (EARLY_EXIT && (dec_d != RES_NONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      idx_q    <= '0;
      dec_q    <= RES_NONE;
      flags_q  <= RES_NONE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        SHIFT: begin
          if (last_bit) begin
            flags_q <= (dec_d == RES_NONE) ? RES_EQ : dec_d;
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            idx_q <= idx_q - 1'b1;
            dec_q <= dec_d;
          end
        end
        default: begin
          done_q <= 1'b0;
          if (start) begin
            a_q      <= A;
            b_q      <= B;
            signed_q <= signed_mode;
            idx_q    <= MSB_IDX;
            dec_q    <= RES_NONE;
            flags_q  <= RES_NONE;
            state_q  <= SHIFT;
            busy_q   <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign A_greater_B = flags_q[2];
  assign A_equal_B   = flags_q[1];
  assign A_less_B    = flags_q[0];

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// tb/tb_serial_magnitude_comparator.sv - randomized and directed bench for both early-exit settings
module tb_serial_magnitude_comparator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       signed_mode = 1'b0;
  logic [7:0] A = 8'h00;
  logic [7:0] B = 8'h00;

  logic busy_ee, done_ee, gt_ee, eq_ee, lt_ee;
  logic busy_fs, done_fs, gt_fs, eq_fs, lt_fs;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_magnitude_comparator #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut_ee (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode), .A(A), .B(B),
    .busy(busy_ee), .done(done_ee), .A_greater_B(gt_ee), .A_equal_B(eq_ee), .A_less_B(lt_ee)
  );

  serial_magnitude_comparator #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut_fs (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode), .A(A), .B(B),
    .busy(busy_fs), .done(done_fs), .A_greater_B(gt_fs), .A_equal_B(eq_fs), .A_less_B(lt_fs)
  );

  function automatic logic [2:0] ref_flags(input logic [7:0] a, input logic [7:0] b, input logic sm);
    int ai;
    int bi;
    ai = sm ? int'($signed(a)) : int'(a);
    bi = sm ? int'($signed(b)) : int'(b);
    if (ai > bi)      return 3'b100;
    else if (ai < bi) return 3'b001;
    else              return 3'b010;
  endfunction

  function automatic int ref_bits(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] d;
    d = a ^ b;
    for (int i = 7; i >= 0; i--) begin
      if (d[i]) return 8 - i;
    end
    return 8;
  endfunction

  // Launches one compare and measures both instances; latency -1 means no done within budget
  task automatic run_compare(input logic [7:0] a, input logic [7:0] b, input logic sm,
                             output int lat_ee, output int lat_fs,
                             output logic [2:0] fl_ee, output logic [2:0] fl_fs,
                             output int busy_cnt, output int busy_flag_bad);
    int n;
    @(negedge clk);
    A = a; B = b; signed_mode = sm; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    A = $urandom; B = $urandom; signed_mode = $urandom;
    lat_ee = -1; lat_fs = -1; fl_ee = 3'b000; fl_fs = 3'b000;
    busy_cnt = busy_ee ? 1 : 0;
    busy_flag_bad = 0;
    n = 0;
    while ((lat_ee < 0 || lat_fs < 0) && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (busy_ee) busy_cnt++;
      if ((busy_ee && {gt_ee, eq_ee, lt_ee} != 3'b000) || (busy_fs && {gt_fs, eq_fs, lt_fs} != 3'b000))
        busy_flag_bad++;
      if (done_ee && lat_ee < 0) begin lat_ee = n; fl_ee = {gt_ee, eq_ee, lt_ee}; end
      if (done_fs && lat_fs < 0) begin lat_fs = n; fl_fs = {gt_fs, eq_fs, lt_fs}; end
    end
  endtask

  task automatic test_reset;
    int seen_done;
    checks++;
    if ({busy_ee, done_ee, gt_ee, eq_ee, lt_ee, busy_fs, done_fs, gt_fs, eq_fs, lt_fs} !== 10'b0) begin
      failures++;
      $display("FAIL reset_state actual=%b required=0", {busy_ee, done_ee, gt_ee, eq_ee, lt_ee});
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    A = 8'h01; B = 8'h00; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (busy_ee !== 1'b1) begin
      failures++;
      $display("FAIL reset_pre_busy actual=%b required=1", busy_ee);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy_ee, done_ee, gt_ee, eq_ee, lt_ee, busy_fs, done_fs, gt_fs, eq_fs, lt_fs} !== 10'b0) begin
      failures++;
      $display("FAIL reset_async actual=%b required=0", {busy_ee, done_ee, gt_ee, eq_ee, lt_ee, busy_fs, done_fs});
    end
    @(negedge clk); rst_n = 1'b1;
    seen_done = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done_ee || done_fs || busy_ee || busy_fs) seen_done++;
    end
    checks++;
    if (seen_done != 0) begin
      failures++;
      $display("FAIL reset_no_done actual=%0d required=0", seen_done);
    end
  endtask

  task automatic test_directed;
    logic [7:0] ta[6] = '{8'h80, 8'h80, 8'h5A, 8'h04, 8'h10, 8'h00};
    logic [7:0] tb[6] = '{8'h7F, 8'h7F, 8'h5A, 8'h05, 8'h00, 8'hFF};
    logic       ts[6] = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b1};
    logic [2:0] tf[6] = '{3'b100, 3'b001, 3'b010, 3'b001, 3'b100, 3'b100};
    int         tj[6] = '{1, 1, 8, 8, 4, 1};
    int le, lf, bc, bb;
    logic [2:0] fe, ff;
    for (int i = 0; i < 6; i++) begin
      run_compare(ta[i], tb[i], ts[i], le, lf, fe, ff, bc, bb);
      checks += 5;
      if (le != tj[i]) begin failures++; $display("FAIL dir%0d_lat_ee actual=%0d required=%0d", i, le, tj[i]); end
      if (lf != 8)     begin failures++; $display("FAIL dir%0d_lat_fs actual=%0d required=8", i, lf); end
      if (fe !== tf[i]) begin failures++; $display("FAIL dir%0d_flags_ee actual=%b required=%b", i, fe, tf[i]); end
      if (ff !== tf[i]) begin failures++; $display("FAIL dir%0d_flags_fs actual=%b required=%b", i, ff, tf[i]); end
      if (bc != tj[i]) begin failures++; $display("FAIL dir%0d_busy_cycles actual=%0d required=%0d", i, bc, tj[i]); end
    end
  endtask

  task automatic test_start_during_shift;
    int n;
    int lat;
    logic [2:0] fl;
    @(negedge clk);
    A = 8'h10; B = 8'h00; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    A = 8'h00; B = 8'hFF; signed_mode = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = -1; fl = 3'b000; n = 1;
    while (lat < 0 && n < 40) begin
      @(posedge clk); #1; n++;
      if (done_ee) begin lat = n; fl = {gt_ee, eq_ee, lt_ee}; end
    end
    checks += 2;
    if (lat != 4)       begin failures++; $display("FAIL shift_start_lat actual=%0d required=4", lat); end
    if (fl !== 3'b100)  begin failures++; $display("FAIL shift_start_flags actual=%b required=100", fl); end
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if ({gt_fs, eq_fs, lt_fs, busy_ee, busy_fs} !== 5'b10000) begin
      failures++;
      $display("FAIL shift_start_fs_flags actual=%b required=10000", {gt_fs, eq_fs, lt_fs, busy_ee, busy_fs});
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    A = 8'h80; B = 8'h7F; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    A = 8'h00; B = 8'hFF;
    @(posedge clk); #1;
    checks++;
    if ({done_ee, gt_ee, eq_ee, lt_ee} !== 4'b1100) begin
      failures++; $display("FAIL b2b_first actual=%b required=1100", {done_ee, gt_ee, eq_ee, lt_ee});
    end
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if ({busy_ee, done_ee, gt_ee, eq_ee, lt_ee} !== 5'b10000) begin
      failures++; $display("FAIL b2b_accept actual=%b required=10000", {busy_ee, done_ee, gt_ee, eq_ee, lt_ee});
    end
    @(posedge clk); #1;
    checks++;
    if ({done_ee, gt_ee, eq_ee, lt_ee} !== 4'b1001) begin
      failures++; $display("FAIL b2b_second actual=%b required=1001", {done_ee, gt_ee, eq_ee, lt_ee});
    end
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if ({gt_fs, eq_fs, lt_fs, busy_fs} !== 4'b1000) begin
      failures++; $display("FAIL b2b_fs_first actual=%b required=1000", {gt_fs, eq_fs, lt_fs, busy_fs});
    end
  endtask

  task automatic test_random;
    int le, lf, bc, bb, j;
    logic [7:0] a, b;
    logic sm;
    logic [2:0] fe, ff, exp;
    for (int i = 0; i < 40; i++) begin
      a = $urandom; b = $urandom; sm = $urandom;
      if (i % 8 == 0) b = a;
      if (i % 8 == 1) b = a ^ 8'h01;
      exp = ref_flags(a, b, sm);
      j = ref_bits(a, b);
      run_compare(a, b, sm, le, lf, fe, ff, bc, bb);
      @(posedge clk); #1;
      checks += 7;
      if (fe !== exp) begin failures++; $display("FAIL rnd_flags_ee a=%h b=%h s=%b actual=%b required=%b", a, b, sm, fe, exp); end
      if (ff !== exp) begin failures++; $display("FAIL rnd_flags_fs a=%h b=%h s=%b actual=%b required=%b", a, b, sm, ff, exp); end
      if (le != j)    begin failures++; $display("FAIL rnd_lat_ee a=%h b=%h actual=%0d required=%0d", a, b, le, j); end
      if (lf != 8)    begin failures++; $display("FAIL rnd_lat_fs a=%h b=%h actual=%0d required=8", a, b, lf); end
      if (bc != j)    begin failures++; $display("FAIL rnd_busy a=%h b=%h actual=%0d required=%0d", a, b, bc, j); end
      if (bb != 0)    begin failures++; $display("FAIL rnd_flags_while_busy actual=%0d required=0", bb); end
      if ({gt_ee, eq_ee, lt_ee} !== exp) begin
        failures++; $display("FAIL rnd_hold_ee actual=%b required=%b", {gt_ee, eq_ee, lt_ee}, exp);
      end
    end
  endtask

  initial begin
    #2;
    test_reset;
    test_directed;
    test_start_during_shift;
    test_back_to_back;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
